// File: rtl/bist_responder_if.sv
// Control/response bundle between the BIST controller side and the responder.
// The controller side owns the strobes and the CUT response; the responder owns the results.
interface bist_responder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             mode;
    logic             init;
    logic             running;
    logic             finish;
    logic             bist_end;
    logic [WIDTH-1:0] cut_response;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] signature;
    logic [15:0]      pattern_count;
    logic             done;
    logic             pass;
    logic             fail;
    logic             proto_err;

    modport master (
        output mode, init, running, finish, bist_end, cut_response,
        input  pattern, signature, pattern_count, done, pass, fail, proto_err
    );

    modport slave (
        input  mode, init, running, finish, bist_end, cut_response,
        output pattern, signature, pattern_count, done, pass, fail, proto_err
    );
endinterface

// File: rtl/bist_responder.sv
// BIST target-side responder: Galois LFSR pattern source, MISR compactor,
// pass/fail grading at finish and sticky control-sequence violation flag.
module bist_responder #(
    parameter int unsigned      WIDTH             = 8,
    parameter logic [WIDTH-1:0] LFSR_SEED         = 8'h01,
    parameter logic [WIDTH-1:0] LFSR_TAPS         = 8'hB8,
    parameter logic [WIDTH-1:0] MISR_TAPS         = 8'hB8,
    parameter logic [WIDTH-1:0] GOLDEN            = 8'h90,
    parameter int unsigned      EXPECTED_PATTERNS = 0
) (
    input  logic              clock,
    input  logic              reset,
    bist_responder_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] misr_q, misr_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             done_q, pass_q, fail_q, perr_q;
    logic             grade_now, grade_applied;
    logic             unused_bist_end;

    function automatic logic grade(input logic [WIDTH-1:0] sig, input logic [15:0] cnt);
        return (sig == GOLDEN) &&
               ((EXPECTED_PATTERNS == 0) || (cnt == 16'(EXPECTED_PATTERNS)));
    endfunction

    always_comb begin
        lfsr_d        = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        misr_d        = {misr_q[WIDTH-2:0], 1'b0} ^ (misr_q[WIDTH-1] ? MISR_TAPS : '0)
                        ^ bus.cut_response;
        cnt_d         = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
        grade_now     = grade(misr_q, cnt_q);
        // finish coinciding with mode grades the post-pattern values
        grade_applied = grade(misr_d, cnt_d);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            misr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else if (bus.init) begin
            state_q <= ARMED;
            lfsr_q  <= LFSR_SEED;
            misr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            perr_q  <= bus.mode | bus.finish;
        end else begin
            case (state_q)
                ARMED, RUN: begin
                    if (bus.mode) begin
                        lfsr_q  <= lfsr_d;
                        misr_q  <= misr_d;
                        cnt_q   <= cnt_d;
                        state_q <= RUN;
                        if (bus.finish) begin
                            perr_q  <= 1'b1;
                            done_q  <= 1'b1;
                            pass_q  <= grade_applied;
                            fail_q  <= !grade_applied;
                            state_q <= DONE;
                        end
                    end else if (bus.finish) begin
                        done_q  <= 1'b1;
                        pass_q  <= grade_now;
                        fail_q  <= !grade_now;
                        state_q <= DONE;
                    end else if (state_q == RUN && !bus.running) begin
                        perr_q <= 1'b1;
                    end
                end
                default: begin
                    if (bus.mode || bus.finish) perr_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.pattern       = lfsr_q;
    assign bus.signature     = misr_q;
    assign bus.pattern_count = cnt_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.fail          = fail_q;
    assign bus.proto_err     = perr_q;

    assign unused_bist_end = bus.bist_end;

endmodule

// File: tb/tb_bist_responder.sv
// Directed bench for bist_responder: two instances (count check off / count of 4)
// compared every cycle against a behavioural model, plus literal pins.
module tb_bist_responder;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 0;

    bist_responder_if #(.WIDTH(8)) if0 ();
    bist_responder_if #(.WIDTH(8)) if1 ();

    assign if1.mode         = if0.mode;
    assign if1.init         = if0.init;
    assign if1.running      = if0.running;
    assign if1.finish       = if0.finish;
    assign if1.bist_end     = if0.bist_end;
    assign if1.cut_response = if0.cut_response;

    bist_responder #(.WIDTH(8)) dut0 (
        .clock (clk),
        .reset (rst_n),
        .bus   (if0)
    );

    bist_responder #(.WIDTH(8), .EXPECTED_PATTERNS(4)) dut1 (
        .clock (clk),
        .reset (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model
    bit [7:0] m_lfsr, m_misr;
    int       m_cnt;
    bit       m_done, m_pass0, m_fail0, m_pass1, m_fail1, m_perr;
    bit       m_active, m_started;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lfsr = 8'h01; m_misr = 8'h00; m_cnt = 0;
        m_done = 0; m_pass0 = 0; m_fail0 = 0; m_pass1 = 0; m_fail1 = 0; m_perr = 0;
        m_active = 0; m_started = 0;
    endtask

    task automatic model_grade();
        m_done  = 1;
        m_pass0 = (m_misr == 8'h90);
        m_fail0 = !m_pass0;
        m_pass1 = (m_misr == 8'h90) && (m_cnt == 4);
        m_fail1 = !m_pass1;
    endtask

    task automatic model_step(input bit r, input bit ini, input bit md, input bit run,
                              input bit fin, input bit [7:0] cut);
        if (!r) begin
            model_reset();
        end else if (ini) begin
            model_reset();
            m_perr   = md | fin;
            m_active = 1;
        end else if (!m_active) begin
            if (md || fin) m_perr = 1;
        end else begin
            if (md) begin
                m_misr    = ((m_misr << 1) & 8'hFF) ^ ((m_misr >= 8'h80) ? 8'hB8 : 8'h00) ^ cut;
                m_lfsr    = (m_lfsr >> 1) ^ ((m_lfsr % 2 == 1) ? 8'hB8 : 8'h00);
                m_cnt     = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                m_started = 1;
            end
            if (fin) begin
                if (md) m_perr = 1;
                model_grade();
                m_active = 0;
            end else if (!md && m_started && !run) begin
                m_perr = 1;
            end
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, return at negedge.
    task automatic cyc(input bit r, input bit ini, input bit md, input bit run,
                       input bit fin, input bit be, input bit [7:0] cut);
        rst_n            = r;
        if0.init         = ini;
        if0.mode         = md;
        if0.running      = run;
        if0.finish       = fin;
        if0.bist_end     = be;
        if0.cut_response = cut;
        @(posedge clk);
        model_step(r, ini, md, run, fin, cut);
        chk_en = 1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pattern0",   if0.pattern,       m_lfsr);
            chk("sig0",       if0.signature,     m_misr);
            chk("count0",     if0.pattern_count, m_cnt);
            chk("done0",      if0.done,          m_done);
            chk("pass0",      if0.pass,          m_pass0);
            chk("fail0",      if0.fail,          m_fail0);
            chk("perr0",      if0.proto_err,     m_perr);
            chk("pass1",      if1.pass,          m_pass1);
            chk("fail1",      if1.fail,          m_fail1);
            chk("done1",      if1.done,          m_done);
            chk("pf_excl0",   if0.pass & if0.fail, 1'b0);
        end
    end

    // Loopback run: 3 patterns separated by gap cycles, then finish. flip xors bit 0 of pattern 2.
    task automatic loopback(input bit flip);
        cyc(1, 1, 0, 0, 0, 0, 8'h00);
        cyc(1, 0, 1, 1, 0, 0, m_lfsr);
        cyc(1, 0, 0, 1, 0, 0, 8'h00);
        cyc(1, 0, 1, 1, 0, 0, m_lfsr ^ (flip ? 8'h01 : 8'h00));
        cyc(1, 0, 0, 1, 0, 0, 8'h00);
        cyc(1, 0, 1, 1, 0, 0, m_lfsr);
        cyc(1, 0, 0, 1, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 1, 0, 8'h00);
    endtask

    initial begin
        if0.init = 0; if0.mode = 0; if0.running = 0; if0.finish = 0;
        if0.bist_end = 0; if0.cut_response = '0; rst_n = 0;

        // Reset values
        cyc(0, 0, 0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        chk("rst_pattern", if0.pattern, 8'h01);
        chk("rst_sig",     if0.signature, 8'h00);
        chk("rst_count",   if0.pattern_count, 16'd0);
        chk("rst_flags",   {if0.done, if0.pass, if0.fail, if0.proto_err}, 4'b0000);

        // LFSR sequence with zero response
        cyc(1, 1, 0, 0, 0, 0, 8'h00);
        chk("seq0", if0.pattern, 8'h01);
        cyc(1, 0, 1, 1, 0, 0, 8'h00); chk("seq1", if0.pattern, 8'hB8);
        cyc(1, 0, 1, 1, 0, 0, 8'h00); chk("seq2", if0.pattern, 8'h5C);
        cyc(1, 0, 1, 1, 0, 0, 8'h00); chk("seq3", if0.pattern, 8'h2E);
        cyc(1, 0, 1, 1, 0, 0, 8'h00); chk("seq4", if0.pattern, 8'h17);
        chk("seq_sig",   if0.signature, 8'h00);
        chk("seq_count", if0.pattern_count, 16'd4);

        // Good loopback
        loopback(0);
        chk("lb_sig",   if0.signature, 8'h90);
        chk("lb_res0",  {if0.done, if0.pass, if0.fail}, 3'b110);
        chk("lb_res1",  {if1.done, if1.pass, if1.fail}, 3'b101);
        cyc(1, 0, 0, 0, 0, 1, 8'h00);
        chk("done_hold", {if0.done, if0.pass, if0.proto_err}, 3'b110);

        // Corrupted loopback
        loopback(1);
        chk("bad_sig", if0.signature, 8'h92);
        chk("bad_res", {if0.done, if0.pass, if0.fail}, 3'b101);

        // Protocol errors
        cyc(0, 0, 0, 0, 0, 0, 8'h00);
        cyc(1, 0, 1, 0, 0, 0, 8'h00);
        chk("idle_mode_perr",  if0.proto_err, 1'b1);
        chk("idle_mode_count", if0.pattern_count, 16'd0);
        cyc(1, 1, 0, 0, 0, 0, 8'h00);
        chk("clean_init", if0.proto_err, 1'b0);
        cyc(1, 0, 1, 1, 0, 0, 8'h00);
        cyc(1, 0, 1, 1, 1, 0, 8'h00);
        chk("fin_mode", {if0.proto_err, if0.done}, 2'b11);
        chk("fin_mode_count", if0.pattern_count, 16'd2);
        cyc(1, 1, 0, 0, 0, 0, 8'h00);
        cyc(1, 0, 1, 1, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        chk("run_drop", if0.proto_err, 1'b1);
        cyc(1, 1, 0, 0, 1, 0, 8'h00);
        chk("init_fin", {if0.proto_err, if0.pattern_count}, {1'b1, 16'd0});

        // Reset mid-run
        cyc(1, 1, 0, 0, 0, 0, 8'h00);
        cyc(1, 0, 1, 1, 0, 0, 8'h33);
        cyc(1, 0, 1, 1, 0, 0, 8'h44);
        cyc(0, 1, 0, 1, 0, 0, 8'h00);
        chk("midrst", {if0.pattern, if0.signature, if0.pattern_count},
                      {8'h01, 8'h00, 16'd0});

        // init from DONE
        loopback(0);
        cyc(1, 1, 0, 0, 0, 0, 8'h00);
        chk("redo", {if0.done, if0.pass, if0.fail, if0.pattern}, {3'b000, 8'h01});
        cyc(1, 0, 1, 1, 0, 0, 8'h00);
        chk("redo_armed", if0.pattern, 8'hB8);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
